// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Transmit side of the CPU UART link. Bytes arrive over a valid/ready
//   handshake, are buffered in a small FIFO and are sent as 8N1 frames
//   (start bit, 8 data bits LSB first, stop bit) on serial_out. Each line
//   symbol lasts CLOCK_FREQ / BAUD_RATE clock cycles.
//
// Ports
//   clk            core clock, all state changes on the rising edge
//   rst            asynchronous, active-high reset
//   data_in        byte to transmit
//   data_in_valid  producer has a byte on data_in
//   data_in_ready  FIFO can accept a byte (transfer on valid && ready)
//   serial_out     registered TX line, idles high
//   tx_busy        frame in progress or bytes still buffered
//   fifo_count     bytes held in the FIFO (excludes the byte being shifted)
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int BW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Serializer state
  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic          push;
  logic          pop;
  logic          baud_last;
  logic          fifo_nonempty;
  logic [7:0]    fifo_head;

  assign baud_last     = (baud_q == BAUD_LAST);
  assign fifo_nonempty = (count_q != '0);
  assign fifo_head     = mem_q[rd_ptr_q];

  assign data_in_ready = (count_q < DEPTH_C);
  assign push          = data_in_valid && data_in_ready;

  // The shifter is loaded either from IDLE or at the end of a stop bit;
  // loading at the stop boundary keeps back-to-back frames gap-free.
  assign pop = fifo_nonempty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

  assign serial_out = tx_q;
  assign tx_busy    = (state_q != S_IDLE) || fifo_nonempty;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (fifo_nonempty) begin
            shift_q <= fifo_head;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        // shift_q already holds the next bit in position 0, so the line is
        // driven straight from it at every symbol boundary.
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (fifo_nonempty) begin
              shift_q <= fifo_head;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  localparam int SET   = 10;
  localparam int C_SET = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  logic [7:0] c_data = '0;
  logic       c_valid = 1'b0;
  logic       c_ready;
  logic       c_serial;
  logic       c_busy;
  logic [2:0] c_count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [7:0] exp_q[$];
  logic [7:0] c_exp_q[$];
  int         start_q[$];

  bit         mon_active = 1'b0;
  int         mon_sym = 0;
  int         mon_cyc = 0;
  logic [7:0] mon_byte = '0;
  logic       mon_bit;
  int         frames_done = 0;

  logic [7:0] t3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int         acc [6];

  uart_transmitter #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count)
  );

  uart_transmitter #(
    .CLOCK_FREQ (200),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (4)
  ) dut_corner (
    .clk           (clk),
    .rst           (rst),
    .data_in       (c_data),
    .data_in_valid (c_valid),
    .data_in_ready (c_ready),
    .serial_out    (c_serial),
    .tx_busy       (c_busy),
    .fifo_count    (c_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: pops the expected byte when a start bit appears and
  // checks every cycle of every symbol of the main DUT's line.
  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && serial_out === 1'b0) begin
          chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          mon_byte   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          mon_active = 1'b1;
          mon_sym    = 0;
          mon_cyc    = 0;
          start_q.push_back(cycle);
        end
        if (mon_active) begin
          if (mon_sym == 0)      mon_bit = 1'b0;
          else if (mon_sym == 9) mon_bit = 1'b1;
          else                   mon_bit = mon_byte[mon_sym-1];
          chk($sformatf("line byte%02h sym%0d cyc%0d", mon_byte, mon_sym, mon_cyc),
              32'(serial_out), 32'(mon_bit));
          mon_cyc++;
          if (mon_cyc == SET) begin
            mon_cyc = 0;
            mon_sym++;
            if (mon_sym == 10) begin
              mon_active = 1'b0;
              frames_done++;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      step();
      k++;
    end
    chk("frames_done_in_time", 32'(frames_done >= n), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b, output int hs);
    int k = 0;
    data_in       = b;
    data_in_valid = 1'b1;
    while (!data_in_ready && k < 300) begin
      step();
      k++;
    end
    chk("push_ready", 32'(data_in_ready), 32'd1);
    hs = cycle + 1;
    if (data_in_ready) exp_q.push_back(b);
    step();
    data_in_valid = 1'b0;
  endtask

  initial begin
    int hs;
    int fd;
    int base;
    int s0;
    int w;
    bit saw_full;
    logic [7:0] cb;
    logic       cbit;

    // Reset values, checked while rst is high and before any clock edge
    #1;
    rst = 1'b1;
    #1;
    chk("rst_serial", 32'(serial_out), 32'd1);
    chk("rst_ready", 32'(data_in_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_c_serial", 32'(c_serial), 32'd1);
    chk("rst_c_count", 32'(c_count), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // 1: single byte 0xA5, latency and return to idle
    fd = frames_done;
    push_byte(8'hA5, hs);
    chk("t1_serial_before_pop", 32'(serial_out), 32'd1);
    chk("t1_count_queued", 32'(fifo_count), 32'd1);
    chk("t1_busy_queued", 32'(tx_busy), 32'd1);
    step();
    chk("t1_serial_start", 32'(serial_out), 32'd0);
    chk("t1_count_popped", 32'(fifo_count), 32'd0);
    wait_frames(fd + 1, 150);
    chk("t1_latency", 32'(start_q[start_q.size()-1]), 32'(hs + 1));
    chk("t1_busy_in_stop", 32'(tx_busy), 32'd1);
    step();
    chk("t1_busy_idle", 32'(tx_busy), 32'd0);
    chk("t1_serial_idle", 32'(serial_out), 32'd1);
    step();

    // 2: byte 0x00
    fd = frames_done;
    push_byte(8'h00, hs);
    wait_frames(fd + 1, 150);
    chk("t2_busy_last_stop", 32'(tx_busy), 32'd1);
    step();
    chk("t2_busy_idle", 32'(tx_busy), 32'd0);
    step();

    // 3: six bytes with valid held, FIFO fills, byte 6 waits
    fd   = frames_done;
    base = start_q.size();
    saw_full = 1'b0;
    data_in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_in = t3[k];
      w = 0;
      while (!data_in_ready && w < 300) begin
        if (!saw_full) begin
          chk("t3_full_count", 32'(fifo_count), 32'd4);
          saw_full = 1'b1;
        end
        step();
        w++;
      end
      chk("t3_ready", 32'(data_in_ready), 32'd1);
      acc[k] = cycle + 1;
      if (data_in_ready) exp_q.push_back(t3[k]);
      step();
    end
    data_in_valid = 1'b0;
    chk("t3_saw_full", 32'(saw_full), 32'd1);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("t3_consec%0d", k), 32'(acc[k]), 32'(acc[0] + k));
    end
    chk("t3_byte6_accept", 32'(acc[5]), 32'(acc[0] + 2 + 10 * SET));
    wait_frames(fd + 6, 800);
    chk("t3_first_start", 32'(start_q[base]), 32'(acc[0] + 1));
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("t3_gap%0d", i), 32'(start_q[base+i] - start_q[base+i-1]), 32'(10 * SET));
    end
    step();
    chk("t3_busy_idle", 32'(tx_busy), 32'd0);
    chk("t3_count_idle", 32'(fifo_count), 32'd0);
    step();

    // 4: reset during data bit 3 of 0xF0 with two bytes queued
    push_byte(8'hF0, hs);
    push_byte(8'h11, hs);
    push_byte(8'h22, hs);
    chk("t4_count_queued", 32'(fifo_count), 32'd2);
    w = 0;
    while (!(mon_active && mon_sym == 4 && mon_cyc == 3) && w < 200) begin
      step();
      w++;
    end
    chk("t4_reached_bit3", 32'(mon_active && mon_sym == 4), 32'd1);
    chk("t4_line_low_bit3", 32'(serial_out), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t4_rst_serial", 32'(serial_out), 32'd1);
    chk("t4_rst_count", 32'(fifo_count), 32'd0);
    chk("t4_rst_ready", 32'(data_in_ready), 32'd1);
    chk("t4_rst_busy", 32'(tx_busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("t4_flushed_busy", 32'(tx_busy), 32'd0);
    chk("t4_flushed_serial", 32'(serial_out), 32'd1);
    fd = frames_done;
    push_byte(8'h3C, hs);
    wait_frames(fd + 1, 150);
    chk("t4_new_latency", 32'(start_q[start_q.size()-1]), 32'(hs + 1));
    for (int k = 0; k < 20; k++) step();
    chk("t4_no_extra_frames", 32'(frames_done), 32'(fd + 1));
    chk("t4_busy_idle", 32'(tx_busy), 32'd0);

    // 5: push on the same edge the stop state pops, FIFO at 2
    fd   = frames_done;
    base = start_q.size();
    push_byte(8'hA1, hs);
    push_byte(8'hB2, hs);
    push_byte(8'hC3, hs);
    chk("t5_count_two", 32'(fifo_count), 32'd2);
    s0 = start_q[base];
    w = 0;
    while (cycle < s0 + 10 * SET - 1 && w < 200) begin
      step();
      w++;
    end
    chk("t5_count_before", 32'(fifo_count), 32'd2);
    data_in       = 8'hD4;
    data_in_valid = 1'b1;
    chk("t5_ready", 32'(data_in_ready), 32'd1);
    if (data_in_ready) exp_q.push_back(8'hD4);
    step();
    data_in_valid = 1'b0;
    chk("t5_count_after", 32'(fifo_count), 32'd2);
    chk("t5_next_start", 32'(serial_out), 32'd0);
    wait_frames(fd + 4, 500);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t5_gap%0d", i), 32'(start_q[base+i] - start_q[base+i-1]), 32'(10 * SET));
    end
    step();
    chk("t5_busy_idle", 32'(tx_busy), 32'd0);

    // 6: SYMBOL_EDGE_TIME=2 corner, byte 0x81
    c_data  = 8'h81;
    c_valid = 1'b1;
    chk("t6_ready", 32'(c_ready), 32'd1);
    c_exp_q.push_back(8'h81);
    step();
    c_valid = 1'b0;
    chk("t6_serial_before_pop", 32'(c_serial), 32'd1);
    chk("t6_count_queued", 32'(c_count), 32'd1);
    cb = c_exp_q.pop_front();
    for (int k = 0; k < 10 * C_SET; k++) begin
      step();
      if (k / C_SET == 0)      cbit = 1'b0;
      else if (k / C_SET == 9) cbit = 1'b1;
      else                     cbit = cb[k / C_SET - 1];
      chk($sformatf("t6_line cyc%0d", k), 32'(c_serial), 32'(cbit));
    end
    step();
    chk("t6_serial_idle", 32'(c_serial), 32'd1);
    chk("t6_busy_idle", 32'(c_busy), 32'd0);
    chk("t6_count_idle", 32'(c_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
